// File: rtl/simd_result_writer.sv
// simd_result_writer
// Accepts 4-lane vectors of 8-bit output pixels over valid/ready. Each vector
// is serialised into byte writes at row-major addresses of an
// out_width x out_height frame. Lanes that fall past the right edge of a row
// are dropped. A one-cycle done pulse marks the end of the frame.
module simd_result_writer #(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [15:0]       i_out_width,
  input  logic [15:0]       i_out_height,
  input  logic              i_vec_valid,
  output logic              o_vec_ready,
  input  logic [3:0][7:0]   i_vec_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic              i_mem_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [15:0]       x, y;
  logic [15:0]       width_q, height_q;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        lane;
  logic [2:0]        n;
  logic [3:0][7:0]   buffer;

  logic [15:0]       remaining;
  logic [2:0]        n_next;
  logic              cfg_nonzero;
  logic              last_lane;
  logic              row_end;
  logic              last_row;

  // Decode helpers: lane limit for a new vector and end-of-vector/row/frame flags.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    remaining   = width_q - x;
    n_next      = (remaining >= 16'd4) ? 3'd4 : remaining[2:0];
    cfg_nonzero = (i_out_width != 16'd0) && (i_out_height != 16'd0);
    last_lane   = ({1'b0, lane} == (n - 3'd1));
    row_end     = ((x + 16'd1) == width_q);
    last_row    = (y == (height_q - 16'd1));
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_start) state_next = cfg_nonzero ? S_WAIT_VEC : S_DONE;
      end
      S_WAIT_VEC: begin
        if (i_vec_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (i_mem_ready && last_lane) begin
          state_next = (row_end && last_row) ? S_DONE : S_WAIT_VEC;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Datapath registers: frame config, position counters, address and vector buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      width_q  <= '0;
      height_q <= '0;
      addr     <= '0;
      lane     <= '0;
      n        <= '0;
      buffer   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && cfg_nonzero) begin
            width_q  <= i_out_width;
            height_q <= i_out_height;
            addr     <= i_base_addr;
            x        <= '0;
            y        <= '0;
          end
        end
        S_WAIT_VEC: begin
          if (i_vec_valid) begin
            buffer <= i_vec_data;
            n      <= n_next;
            lane   <= '0;
          end
        end
        S_WRITE: begin
          if (i_mem_ready) begin
            addr <= addr + 1'b1;
            lane <= lane + 2'd1;
            // Rows are contiguous, so only x wraps at the row end; addr keeps counting.
            if (last_lane && row_end) begin
              x <= '0;
              if (!last_row) y <= y + 16'd1;
            end else begin
              x <= x + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only; no input reaches an output combinationally.
  assign o_vec_ready = (state == S_WAIT_VEC);
  assign o_mem_we    = (state == S_WRITE);
  assign o_mem_addr  = (state == S_WRITE) ? addr : '0;
  assign o_mem_wdata = (state == S_WRITE) ? buffer[lane] : 8'd0;
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);

endmodule

// File: doc/simd_result_writer.md
# simd_result_writer

Output-side companion of the SIMD downscaling datapath. It accepts 4-lane vectors of interpolated 8-bit output pixels from the SIMD core through a valid/ready handshake. It serialises each vector into byte writes to the output-image memory and generates row-major addresses for an out_width × out_height frame. Lanes past the right edge of a row are dropped, and completion of the frame is signalled with a one-cycle done pulse.

## Interface
- ADDR_W, default 19: output memory address width; covers 640×480 bytes.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  start-of-frame pulse; sampled only in IDLE.
- i_base_addr  input  ADDR_W  byte address of output pixel (0,0); latched on accepted start.
- i_out_width  input  16  output pixels per row; latched on accepted start.
- i_out_height  input  16  output rows; latched on accepted start.
- i_vec_valid  input  1  SIMD result vector valid.
- o_vec_ready  output  1  writer can accept a vector.
- i_vec_data  input  [3:0][7:0]  lane k = pixel at column x+k of the current row.
- o_mem_we  output  1  byte write request.
- o_mem_addr  output  ADDR_W  write address.
- o_mem_wdata  output  8  write data.
- i_mem_ready  input  1  memory accepts the current write this cycle.
- o_busy  output  1  high whenever the state is not IDLE.
- o_done  output  1  one-cycle frame-complete pulse.

## Operation
- Internal registers: state, x, y (16 b each), addr (ADDR_W), lane index (2 b), lane limit n (3 b), vector buffer [3:0][7:0], latched width/height.
- IDLE: o_vec_ready=0, o_mem_we=0.
  - On i_start with width≠0 and height≠0: latch the three config inputs, clear x and y, set addr=base, go to WAIT_VEC.
  - On i_start with width=0 or height=0: go to DONE, no writes.
- WAIT_VEC: o_vec_ready=1.
  - On i_vec_valid&o_vec_ready: capture i_vec_data, set n=min(4, width−x), clear the lane index, go to WRITE.
- WRITE: o_vec_ready=0, o_mem_we=1, o_mem_addr=addr, o_mem_wdata=buffer[lane]. On i_mem_ready:
  - Increment addr, lane index and x.
  - If the lane just written was lane n−1:
    - If x+1=width: clear x. If y=height−1, go to DONE; otherwise increment y and go to WAIT_VEC.
    - Otherwise go to WAIT_VEC.
- DONE: o_done=1 for exactly one cycle, then go to IDLE.
- Rows are contiguous, so addr only ever increments; the address of pixel (x,y) is base+y·width+x, modulo 2^ADDR_W (wraps silently).
- Tail lanes n..3 of the last vector in a row are discarded and never written. The next vector starts at column 0 of the next row.
- i_start is ignored outside IDLE. i_vec_valid is ignored outside WAIT_VEC.
- Total writes per frame = width·height, in strictly increasing address order.

## Timing
- Reset: state=IDLE; o_vec_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_busy and o_done are all 0; internal registers are cleared.
- Reset asserted mid-frame aborts immediately; the frame is not resumed and there is no done pulse.
- All outputs decode from registered state only. There is no combinational path from any input to any output.
- Start accepted at edge N: o_busy=1 and o_vec_ready=1 from cycle N+1.
- Vector accepted at edge M: the first write is presented in cycle M+1.
- With i_mem_ready held at 1, a full vector costs 5 cycles (1 accept + 4 writes). A tail vector costs 1+n cycles.
- While i_mem_ready=0, o_mem_we, o_mem_addr and o_mem_wdata hold stable; there is no skip and no duplicate.
- Final write accepted at edge K: o_done=1 in cycle K+1 and o_busy=0 from cycle K+2. The same timing applies for the zero-size case: start at edge N gives o_done in cycle N+1.
- No simultaneous accept of a vector and a write, since the states are exclusive.

## Test plan
- Width 8, height 2, base 0x100, vectors {0..3},{4..7},{8..11},{12..15}, i_mem_ready=1 -> 16 writes at 0x100..0x10F with data 0..15, 20 cycles, then a single o_done pulse.
- Width 6, height 1, base 0, vectors {A0..A3},{B0..B3} -> 6 writes at addresses 0..5 with data A0..A3,B0,B1; B2 and B3 never written; done after the 6th write.
- Width 4, height 1, i_mem_ready low for 3 cycles during the 2nd byte -> address and data held for 4 cycles, 4 writes total, correct order.
- i_start with width=0 -> o_done in the next cycle, o_mem_we never 1, o_vec_ready never 1.
- rst_n dropped during WRITE of the 3rd byte -> all outputs 0 immediately. A subsequent start with base 0x40 writes from 0x40 correctly.
- i_start pulsed while busy with a different base -> ignored; the frame completes with the original base and width.
